// File: rtl/uart_tx_rx.sv
// 8N1 UART transmitter and receiver sharing one clock. Tx outputs lag the accepted request by one cycle.
// No backpressure: i_TX_DV is dropped unless Tx is idle; o_RX_DV is a one-cycle pulse that cannot be stalled.
module uart_tx_rx #(
    parameter int FPGA_clk_freq = 50000000,
    parameter int baudrate      = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    output logic       o_TX_Active,
    output logic       o_TX_Serial,
    output logic       o_TX_Done,
    input  logic       i_RX_Serial,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte
);

    localparam int CLKS_PER_BIT = FPGA_clk_freq / baudrate;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_CLEANUP
    } state_t;

    // ------------------------------------------------------------------ Tx
    state_t           tx_state, tx_state_nxt;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_nxt;
    logic [2:0]       tx_idx, tx_idx_nxt;
    logic [7:0]       tx_byte, tx_byte_nxt;
    logic             tx_serial_nxt, tx_active_nxt, tx_done_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state    <= S_IDLE;
            tx_cnt      <= '0;
            tx_idx      <= '0;
            tx_byte     <= '0;
            o_TX_Serial <= 1'b1;
            o_TX_Active <= 1'b0;
            o_TX_Done   <= 1'b0;
        end else begin
            tx_state    <= tx_state_nxt;
            tx_cnt      <= tx_cnt_nxt;
            tx_idx      <= tx_idx_nxt;
            tx_byte     <= tx_byte_nxt;
            o_TX_Serial <= tx_serial_nxt;
            o_TX_Active <= tx_active_nxt;
            o_TX_Done   <= tx_done_nxt;
        end
    end

    // Line outputs are registered copies of the current state's drive, so the
    // whole frame appears one cycle after the state machine enters it.
    always_comb begin
        tx_state_nxt  = tx_state;
        tx_cnt_nxt    = tx_cnt;
        tx_idx_nxt    = tx_idx;
        tx_byte_nxt   = tx_byte;
        tx_serial_nxt = 1'b1;
        tx_active_nxt = 1'b0;
        tx_done_nxt   = 1'b0;
        unique case (tx_state)
            S_IDLE: begin
                tx_cnt_nxt = '0;
                tx_idx_nxt = '0;
                if (i_TX_DV) begin
                    tx_byte_nxt  = i_TX_Byte;
                    tx_state_nxt = S_START;
                end
            end
            S_START: begin
                tx_serial_nxt = 1'b0;
                tx_active_nxt = 1'b1;
                if (tx_cnt == BIT_END) begin
                    tx_cnt_nxt   = '0;
                    tx_state_nxt = S_DATA;
                end else begin
                    tx_cnt_nxt = tx_cnt + CNT_ONE;
                end
            end
            S_DATA: begin
                tx_serial_nxt = tx_byte[tx_idx];
                tx_active_nxt = 1'b1;
                if (tx_cnt == BIT_END) begin
                    tx_cnt_nxt = '0;
                    if (tx_idx == 3'd7) begin
                        tx_idx_nxt   = '0;
                        tx_state_nxt = S_STOP;
                    end else begin
                        tx_idx_nxt = tx_idx + 3'd1;
                    end
                end else begin
                    tx_cnt_nxt = tx_cnt + CNT_ONE;
                end
            end
            S_STOP: begin
                tx_active_nxt = 1'b1;
                if (tx_cnt == BIT_END) begin
                    tx_cnt_nxt   = '0;
                    tx_state_nxt = S_CLEANUP;
                end else begin
                    tx_cnt_nxt = tx_cnt + CNT_ONE;
                end
            end
            S_CLEANUP: begin
                tx_done_nxt  = 1'b1;
                tx_state_nxt = S_IDLE;
            end
            default: tx_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------ Rx
    logic             rx_meta, rx_sync;
    state_t           rx_state, rx_state_nxt;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_nxt;
    logic [2:0]       rx_idx, rx_idx_nxt;
    logic [7:0]       rx_shift, rx_shift_nxt;
    logic [7:0]       rx_byte_nxt;
    logic             rx_dv_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_state  <= S_IDLE;
            rx_cnt    <= '0;
            rx_idx    <= '0;
            rx_shift  <= '0;
            o_RX_DV   <= 1'b0;
            o_RX_Byte <= 8'h00;
        end else begin
            rx_meta   <= i_RX_Serial;
            rx_sync   <= rx_meta;
            rx_state  <= rx_state_nxt;
            rx_cnt    <= rx_cnt_nxt;
            rx_idx    <= rx_idx_nxt;
            rx_shift  <= rx_shift_nxt;
            o_RX_DV   <= rx_dv_nxt;
            o_RX_Byte <= rx_byte_nxt;
        end
    end

    // Start bit is re-checked at its midpoint; every later sample is a full
    // bit period apart so it lands mid-bit as well.
    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt;
        rx_idx_nxt   = rx_idx;
        rx_shift_nxt = rx_shift;
        rx_byte_nxt  = o_RX_Byte;
        rx_dv_nxt    = 1'b0;
        unique case (rx_state)
            S_IDLE: begin
                rx_cnt_nxt = '0;
                rx_idx_nxt = '0;
                if (!rx_sync) rx_state_nxt = S_START;
            end
            S_START: begin
                if (rx_cnt == HALF_END) begin
                    rx_cnt_nxt   = '0;
                    rx_state_nxt = rx_sync ? S_IDLE : S_DATA;
                end else begin
                    rx_cnt_nxt = rx_cnt + CNT_ONE;
                end
            end
            S_DATA: begin
                if (rx_cnt == BIT_END) begin
                    rx_cnt_nxt           = '0;
                    rx_shift_nxt[rx_idx] = rx_sync;
                    if (rx_idx == 3'd7) begin
                        rx_idx_nxt   = '0;
                        rx_state_nxt = S_STOP;
                    end else begin
                        rx_idx_nxt = rx_idx + 3'd1;
                    end
                end else begin
                    rx_cnt_nxt = rx_cnt + CNT_ONE;
                end
            end
            S_STOP: begin
                if (rx_cnt == BIT_END) begin
                    rx_cnt_nxt   = '0;
                    rx_state_nxt = S_CLEANUP;
                    if (rx_sync) begin
                        rx_byte_nxt = rx_shift;
                        rx_dv_nxt   = 1'b1;
                    end
                end else begin
                    rx_cnt_nxt = rx_cnt + CNT_ONE;
                end
            end
            S_CLEANUP: begin
                // After a framing error the line may still be low; hold here
                // so that the bad stop bit is not mistaken for a new start.
                if (rx_sync) rx_state_nxt = S_IDLE;
            end
            default: rx_state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_rx.sv
// Scoreboard bench for uart_tx_rx at default parameters (434 clocks per bit).
module tb_uart_tx_rx;

    localparam int CPB      = 434;
    localparam int DONE_LAT = 10 * CPB + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_TX_DV = 1'b0;
    logic [7:0] i_TX_Byte = 8'h00;
    logic       o_TX_Active, o_TX_Serial, o_TX_Done;
    logic       i_RX_Serial;
    logic       o_RX_DV;
    logic [7:0] o_RX_Byte;

    logic loop_en = 1'b1;
    logic drv_line = 1'b1;

    assign i_RX_Serial = loop_en ? (o_TX_Active ? o_TX_Serial : 1'b1) : drv_line;

    uart_tx_rx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_TX_DV    (i_TX_DV),
        .i_TX_Byte  (i_TX_Byte),
        .o_TX_Active(o_TX_Active),
        .o_TX_Serial(o_TX_Serial),
        .o_TX_Done  (o_TX_Done),
        .i_RX_Serial(i_RX_Serial),
        .o_RX_DV    (o_RX_DV),
        .o_RX_Byte  (o_RX_Byte)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } probe_t;

    probe_t     chk_q[$];
    logic [7:0] exp_rx[$];
    int         exp_done[$];
    int         checks = 0;
    int         errors = 0;
    int         act_cnt = 0;

    // Monitor: the only process that compares and counts.
    always @(negedge clk) begin
        while (chk_q.size() != 0) begin
            probe_t p;
            p = chk_q.pop_front();
            checks++;
            if (p.act !== p.exp) begin
                errors++;
                $display("FAIL %s: got %0h expected %0h", p.name, p.act, p.exp);
            end
        end
        if (!rst_n) act_cnt = 0;
        else if (o_TX_Active) act_cnt++;
        if (o_TX_Done) begin
            checks++;
            if (exp_done.size() == 0) begin
                errors++;
                $display("FAIL tx_done_unexpected: pulse at cycle %0d, none expected", cyc);
            end else begin
                int e;
                e = exp_done.pop_front();
                if (cyc != e) begin
                    errors++;
                    $display("FAIL tx_done_cycle: got %0d expected %0d", cyc, e);
                end
            end
            checks++;
            if (act_cnt != 10 * CPB) begin
                errors++;
                $display("FAIL tx_active_len: got %0d expected %0d", act_cnt, 10 * CPB);
            end
            act_cnt = 0;
        end
        if (o_RX_DV) begin
            checks++;
            if (exp_rx.size() == 0) begin
                errors++;
                $display("FAIL rx_dv_unexpected: byte %0h, none expected", o_RX_Byte);
            end else begin
                logic [7:0] eb;
                eb = exp_rx.pop_front();
                if (o_RX_Byte !== eb) begin
                    errors++;
                    $display("FAIL rx_byte: got %0h expected %0h", o_RX_Byte, eb);
                end
            end
        end
    end

    task automatic post(input string n, input logic [31:0] a, input logic [31:0] e);
        probe_t p;
        p.name = n;
        p.act  = a;
        p.exp  = e;
        chk_q.push_back(p);
    endtask

    task automatic send(input logic [7:0] b, input bit expect_it);
        @(negedge clk);
        i_TX_Byte = b;
        i_TX_DV   = 1'b1;
        @(negedge clk);
        i_TX_DV = 1'b0;
        if (expect_it) begin
            exp_rx.push_back(b);
            exp_done.push_back(cyc + DONE_LAT);
        end
    endtask

    task automatic wait_done(input string n);
        int k;
        k = 0;
        while (!o_TX_Done && k < 12 * CPB) begin
            @(negedge clk);
            k++;
        end
        post(n, 32'(k < 12 * CPB), 32'd1);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            drv_line = bits[i];
            repeat (CPB) @(negedge clk);
        end
        drv_line = 1'b1;
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        post("rst_tx_serial", 32'(o_TX_Serial), 32'd1);
        post("rst_tx_active", 32'(o_TX_Active), 32'd0);
        post("rst_tx_done", 32'(o_TX_Done), 32'd0);
        post("rst_rx_dv", 32'(o_RX_DV), 32'd0);
        post("rst_rx_byte", 32'(o_RX_Byte), 32'h00);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Loopback of a single byte.
        send(8'h37, 1'b1);
        wait_done("done_37");
        repeat (20) @(negedge clk);
        post("rx_byte_37", 32'(o_RX_Byte), 32'h37);

        // Back-to-back extremes.
        send(8'h00, 1'b1);
        wait_done("done_00");
        send(8'hFF, 1'b1);
        wait_done("done_ff");
        repeat (20) @(negedge clk);
        post("rx_byte_ff", 32'(o_RX_Byte), 32'hFF);

        // A second request mid-frame must be dropped.
        send(8'h37, 1'b1);
        repeat (1000) @(negedge clk);
        i_TX_Byte = 8'hC3;
        i_TX_DV   = 1'b1;
        @(negedge clk);
        i_TX_DV = 1'b0;
        wait_done("done_37_ignore");
        repeat (200) @(negedge clk);
        post("tx_idle_after_ignored", 32'(o_TX_Active), 32'd0);

        // Short low glitch on the Rx line.
        loop_en  = 1'b0;
        drv_line = 1'b0;
        repeat (100) @(negedge clk);
        drv_line = 1'b1;
        repeat (1000) @(negedge clk);
        post("glitch_byte_kept", 32'(o_RX_Byte), 32'h37);

        // Framing error followed by a good frame.
        rx_frame(8'hA5, 1'b0);
        repeat (1000) @(negedge clk);
        post("ferr_byte_kept", 32'(o_RX_Byte), 32'h37);
        exp_rx.push_back(8'h5A);
        rx_frame(8'h5A, 1'b1);
        repeat (200) @(negedge clk);
        post("rx_byte_5a", 32'(o_RX_Byte), 32'h5A);

        // Reset in the middle of a looped-back frame.
        loop_en = 1'b1;
        send(8'h37, 1'b0);
        repeat (2000) @(negedge clk);
        rst_n = 1'b0;
        #1;
        post("midrst_tx_serial", 32'(o_TX_Serial), 32'd1);
        post("midrst_tx_active", 32'(o_TX_Active), 32'd0);
        repeat (5) @(negedge clk);
        post("midrst_rx_byte", 32'(o_RX_Byte), 32'h00);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        send(8'h37, 1'b1);
        wait_done("done_after_rst");
        repeat (20) @(negedge clk);
        post("rx_byte_after_rst", 32'(o_RX_Byte), 32'h37);

        k = 0;
        while ((exp_rx.size() != 0 || exp_done.size() != 0) && k < 12 * CPB) begin
            @(negedge clk);
            k++;
        end
        post("scoreboard_drained", 32'(exp_rx.size() + exp_done.size()), 32'd0);
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
